pipelined_add_sub: RTL and testbench
====================================

Name: pipelined_add_sub

Overview:
Parametrised successor to the team's 4-bit ripple adder/subtractor. Computes A+B (M=0) or A−B (M=1, as A + ~B + 1) over WIDTH bits. The carry chain is split into STAGES registered segments, so timing closes at wide widths. Sits between operand producers and result consumers using valid/ready handshakes on both sides, and sustains one operation per cycle when the output is not stalled.

Parameters:
WIDTH, 16, operand/result width in bits; WIDTH must be divisible by STAGES, and WIDTH ≥ 2.
STAGES, 4, number of pipeline segments; each segment handles SEG = WIDTH/STAGES bits; STAGES ≥ 1.

Ports:
clk  input  1  single clock; all state updates on rising edge.
rst  input  1  synchronous, active-high reset.
in_valid  input  1  operands a, b, m are valid this cycle.
in_ready  output  1  block accepts operands this cycle.
a  input  WIDTH  operand A.
b  input  WIDTH  operand B.
m  input  1  mode: 0 = add, 1 = subtract.
out_valid  output  1  result fields are valid.
out_ready  input  1  consumer accepts the result this cycle.
sum  output  WIDTH  result bits.
carry  output  1  raw carry out of MSB; in subtract mode, 1 means no borrow (A ≥ B unsigned).
overflow  output  1  two's-complement signed overflow.
zero  output  1  sum == 0.

Behaviour:
- Clock is clk and reset is rst. Reset is synchronous and active-high. It is sampled only on the rising edge of clk.
- Reset: all stage valid bits = 0, out_valid = 0, sum = 0, carry = 0, overflow = 0, zero = 0.
- Reset mid-operation discards all in-flight operations. No result from before reset may appear afterwards. in_ready is 1 in the first cycle after rst deasserts.
- Acceptance: an operation is accepted when in_valid && in_ready at a rising edge.
- Output transfer: a result is consumed when out_valid && out_ready at a rising edge.
- Stall rule (global): stall = out_valid && !out_ready; in_ready = !stall.
  - While stalled, every pipeline register holds its value, including data, valid bits and partial carries.
  - in_ready is combinational from out_valid/out_ready only. It does not depend on in_valid.
- Stage k (k = 0..STAGES-1) computes bits [k*SEG +: SEG] of a + (b XOR {WIDTH{m}}) + cin_k.
  - cin_0 = m.
  - cin_k = registered carry-out of stage k−1.
- Stage k forwards the not-yet-processed upper operand bits and m with the operation. Already-computed lower sum bits are forwarded alongside.
- Latency: exactly STAGES cycles from acceptance to out_valid, when not stalled. With STAGES = 1, the result is registered once, so latency = 1.
- Throughput: 1 result per cycle with out_ready held at 1. Bubbles (in_valid = 0) propagate as invalid slots and never produce out_valid.
- Final result:
  - carry = carry-out of the MSB.
  - overflow = carry into MSB XOR carry out of MSB. Equivalently, operand signs equal after B inversion and sum sign differs.
  - zero = ~|sum.
- sum, carry, overflow and zero are registered together with out_valid and held stable while stalled.
- When out_valid = 0, output data fields hold their last values. Consumers ignore them.
- Ordering: results leave in acceptance order. There is no reordering and no dropping.
- Simultaneous accept and output transfer in the same cycle is legal and required for full throughput.
- Wrap-around: results are modulo 2^WIDTH. No saturation.
- m is captured per operation. Mixing add and sub on consecutive cycles is legal.

Test Plan:
- WIDTH=16, STAGES=4, out_ready=1; accept a=0x0005, b=0x0003, m=1 → exactly 4 cycles later out_valid=1, sum=0x0002, carry=1, overflow=0, zero=0.
- Issue a=0x7FFF, b=0x0001, m=0 → sum=0x8000, carry=0, overflow=1. Then a=0x0003, b=0x0005, m=1 → sum=0xFFFE, carry=0, overflow=0.
- Issue a=0xFFFF, b=0x0001, m=0 → sum=0x0000, carry=1, zero=1, overflow=0. This checks the carry crossing all segment boundaries.
- Stream 10 back-to-back operations (alternating m), then drop out_ready for 3 cycles mid-stream → in_ready=0 exactly while out_valid && !out_ready. The held outputs do not change. After release, all 10 results emerge in order with no duplicates or losses.
- Assert rst for 1 cycle while 3 operations are in flight → the cycle after reset shows out_valid=0 and in_ready=1. None of the 3 results ever appears. A new operation then takes STAGES cycles.
- Repeat the randomised comparison against a software model for STAGES=1 and STAGES=WIDTH (WIDTH=8) → sum, carry and overflow match for 1000 operations.

Source files
------------

// File: rtl/pipelined_add_sub.sv
// Pipelined WIDTH-bit adder/subtractor: the carry chain is cut into STAGES registered
// segments, with valid/ready handshakes on both sides and a global output stall.
`timescale 1ns/1ps
module pipelined_add_sub #(
   parameter int WIDTH  = 16,
   parameter int STAGES = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             m,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             carry,
   output logic             overflow,
   output logic             zero
);

   localparam int SEG  = WIDTH / STAGES;
   localparam int LAST = STAGES - 1;

   logic              stall;
   logic [STAGES-1:0] valid_q, valid_d;
   logic [STAGES-1:0] cy_q, cy_d;
   logic [WIDTH-1:0]  opa_q [STAGES];
   logic [WIDTH-1:0]  opa_d [STAGES];
   logic [WIDTH-1:0]  opb_q [STAGES];
   logic [WIDTH-1:0]  opb_d [STAGES];
   logic [WIDTH-1:0]  res_q [STAGES];
   logic [WIDTH-1:0]  res_d [STAGES];
   logic              ovf_q, ovf_d;
   logic              zero_q, zero_d;

   logic [WIDTH-1:0]  src_a, src_b, src_res;
   logic              src_c, src_v;
   logic [SEG:0]      seg_sum;

   assign stall     = valid_q[LAST] && !out_ready;
   assign in_ready  = !stall;
   assign out_valid = valid_q[LAST];
   assign sum       = res_q[LAST];
   assign carry     = cy_q[LAST];
   assign overflow  = ovf_q;
   assign zero      = zero_q;

   // m is folded in at entry (B inverted, cin_0 = m), so later stages only need the carry.
   always_comb begin
      valid_d = valid_q;
      cy_d    = cy_q;
      ovf_d   = ovf_q;
      zero_d  = zero_q;
      for (int k = 0; k < STAGES; k++) begin
         opa_d[k] = opa_q[k];
         opb_d[k] = opb_q[k];
         res_d[k] = res_q[k];
      end
      src_a   = a;
      src_b   = b ^ {WIDTH{m}};
      src_res = '0;
      src_c   = m;
      src_v   = in_valid;
      seg_sum = '0;
      if (!stall) begin
         for (int k = 0; k < STAGES; k++) begin
            seg_sum = {1'b0, src_a[k*SEG +: SEG]} + {1'b0, src_b[k*SEG +: SEG]}
                    + {{SEG{1'b0}}, src_c};
            valid_d[k] = src_v;
            // The output stage keeps its last data when a bubble arrives.
            if (k != LAST || src_v) begin
               opa_d[k]                = src_a;
               opb_d[k]                = src_b;
               res_d[k]                = src_res;
               res_d[k][k*SEG +: SEG]  = seg_sum[SEG-1:0];
               cy_d[k]                 = seg_sum[SEG];
            end else begin
               cy_d[k] = cy_q[k];
            end
            src_a   = opa_q[k];
            src_b   = opb_q[k];
            src_res = res_q[k];
            src_c   = cy_q[k];
            src_v   = valid_q[k];
         end
         if (valid_d[LAST]) begin
            ovf_d  = (opa_d[LAST][WIDTH-1] == opb_d[LAST][WIDTH-1]) &&
                     (res_d[LAST][WIDTH-1] != opa_d[LAST][WIDTH-1]);
            zero_d = ~|res_d[LAST];
         end else begin
            ovf_d  = ovf_q;
            zero_d = zero_q;
         end
      end else begin
         valid_d = valid_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= '0;
         cy_q    <= '0;
         ovf_q   <= 1'b0;
         zero_q  <= 1'b0;
         for (int k = 0; k < STAGES; k++) begin
            opa_q[k] <= '0;
            opb_q[k] <= '0;
            res_q[k] <= '0;
         end
      end else begin
         valid_q <= valid_d;
         cy_q    <= cy_d;
         ovf_q   <= ovf_d;
         zero_q  <= zero_d;
         for (int k = 0; k < STAGES; k++) begin
            opa_q[k] <= opa_d[k];
            opb_q[k] <= opb_d[k];
            res_q[k] <= res_d[k];
         end
      end
   end

endmodule

// File: tb/tb_pipelined_add_sub.sv
// Scoreboard bench for pipelined_add_sub: directed 16-bit/4-stage checks plus
// randomised 8-bit runs with STAGES=1 and STAGES=8.
`timescale 1ns/1ps
module tb_pipelined_add_sub;

   logic clk = 1'b0;
   logic rst;

   logic        iv0, ir0, m0, ov0, or0, c0, o0, z0;
   logic [15:0] a0, b0, s0;
   logic        iv1, ir1, m1, ov1, or1, c1, o1, z1;
   logic [7:0]  a1, b1, s1;
   logic        iv2, ir2, m2, ov2, or2, c2, o2, z2;
   logic [7:0]  a2, b2, s2;

   logic [18:0] q0[$];
   logic [18:0] q1[$];
   logic [18:0] q2[$];
   int n_checks = 0;
   int n_fail   = 0;
   int n_out0   = 0;
   int acc1     = 0;
   int acc2     = 0;
   int base;
   int w;

   always #5 clk = ~clk;

   pipelined_add_sub #(.WIDTH(16), .STAGES(4)) dut0 (
      .clk(clk), .rst(rst), .in_valid(iv0), .in_ready(ir0), .a(a0), .b(b0), .m(m0),
      .out_valid(ov0), .out_ready(or0), .sum(s0), .carry(c0), .overflow(o0), .zero(z0));
   pipelined_add_sub #(.WIDTH(8), .STAGES(1)) dut1 (
      .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1), .a(a1), .b(b1), .m(m1),
      .out_valid(ov1), .out_ready(or1), .sum(s1), .carry(c1), .overflow(o1), .zero(z1));
   pipelined_add_sub #(.WIDTH(8), .STAGES(8)) dut2 (
      .clk(clk), .rst(rst), .in_valid(iv2), .in_ready(ir2), .a(a2), .b(b2), .m(m2),
      .out_valid(ov2), .out_ready(or2), .sum(s2), .carry(c2), .overflow(o2), .zero(z2));

   // Reference result packed as {zero, overflow, carry, sum[15:0]} for a w-bit datapath.
   function automatic logic [18:0] model(input int wd, input logic [15:0] a, input logic [15:0] b,
                                         input logic m);
      logic [16:0] full;
      logic [15:0] s;
      logic        c, ov, sa, sb, ss;
      full = {1'b0, a} + {1'b0, b};
      if (m) s = a - b;
      else   s = full[15:0];
      if (wd < 16) s = s & ((16'd1 << wd) - 16'd1);
      c  = m ? (a >= b) : full[wd];
      sa = a[wd-1];
      sb = b[wd-1];
      ss = s[wd-1];
      ov = m ? ((sa != sb) && (ss != sa)) : ((sa == sb) && (ss != sa));
      return {(s == 16'd0), ov, c, s};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (rst) q0.delete();
      else begin
         if (ov0 && or0) begin
            n_out0++;
            chk("w16s4 output expected", 32'(q0.size() != 0), 32'd1);
            if (q0.size() != 0) chk("w16s4 result", {13'd0, z0, o0, c0, s0}, {13'd0, q0.pop_front()});
         end
         if (iv0 && ir0) q0.push_back(model(16, a0, b0, m0));
      end
   end

   always @(negedge clk) begin
      if (rst) q1.delete();
      else begin
         if (ov1 && or1) begin
            chk("w8s1 output expected", 32'(q1.size() != 0), 32'd1);
            if (q1.size() != 0) chk("w8s1 result", {13'd0, z1, o1, c1, 8'h00, s1}, {13'd0, q1.pop_front()});
         end
         if (iv1 && ir1) begin
            q1.push_back(model(8, {8'h00, a1}, {8'h00, b1}, m1));
            acc1++;
         end
      end
   end

   always @(negedge clk) begin
      if (rst) q2.delete();
      else begin
         if (ov2 && or2) begin
            chk("w8s8 output expected", 32'(q2.size() != 0), 32'd1);
            if (q2.size() != 0) chk("w8s8 result", {13'd0, z2, o2, c2, 8'h00, s2}, {13'd0, q2.pop_front()});
         end
         if (iv2 && ir2) begin
            q2.push_back(model(8, {8'h00, a2}, {8'h00, b2}, m2));
            acc2++;
         end
      end
   end

   // Called at posedge+1 with in_ready high; checks latency and the hand-computed result.
   task automatic single(input logic [15:0] a, input logic [15:0] b, input logic m,
                         input logic [18:0] exp);
      int n;
      a0 = a; b0 = b; m0 = m; iv0 = 1'b1;
      @(posedge clk); #1 iv0 = 1'b0;
      n = 1;
      while (!ov0 && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      chk("w16s4 latency", n, 32'd4);
      chk("w16s4 directed", {13'd0, z0, o0, c0, s0}, {13'd0, exp});
      @(posedge clk); #1;
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      iv0 = 1'b0; a0 = 16'h0; b0 = 16'h0; m0 = 1'b0; or0 = 1'b1;
      iv1 = 1'b0; a1 = 8'h0;  b1 = 8'h0;  m1 = 1'b0; or1 = 1'b1;
      iv2 = 1'b0; a2 = 8'h0;  b2 = 8'h0;  m2 = 1'b0; or2 = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      chk("reset out_valid", {31'd0, ov0}, 32'd0);
      chk("reset in_ready", {31'd0, ir0}, 32'd1);
      chk("reset data", {13'd0, z0, o0, c0, s0}, 32'd0);
      chk("reset out_valid w8", {30'd0, ov1, ov2}, 32'd0);

      single(16'h0005, 16'h0003, 1'b1, {1'b0, 1'b0, 1'b1, 16'h0002});
      single(16'h7FFF, 16'h0001, 1'b0, {1'b0, 1'b1, 1'b0, 16'h8000});
      single(16'h0003, 16'h0005, 1'b1, {1'b0, 1'b0, 1'b0, 16'hFFFE});
      single(16'hFFFF, 16'h0001, 1'b0, {1'b1, 1'b0, 1'b1, 16'h0000});
      single(16'h8000, 16'h0001, 1'b1, {1'b0, 1'b1, 1'b1, 16'h7FFF});

      base = n_out0;
      fork
         begin
            for (int i = 0; i < 10; i++) begin
               int wt;
               a0 = 16'(i * 16'h1357 + 16'h00F0);
               b0 = 16'(16'h8000 - i * 16'h0101);
               m0 = i[0];
               iv0 = 1'b1;
               wt = 0;
               @(negedge clk);
               while (!ir0 && wt < 20) begin
                  @(negedge clk);
                  wt++;
               end
               @(posedge clk); #1;
            end
            iv0 = 1'b0;
         end
         begin
            repeat (6) @(posedge clk);
            #1 or0 = 1'b0;
            repeat (3) begin
               @(negedge clk);
               chk("stall in_ready", {31'd0, ir0}, 32'd0);
               chk("stall out_valid", {31'd0, ov0}, 32'd1);
               chk("stall queue", 32'(q0.size() > 0), 32'd1);
               if (q0.size() > 0) chk("stall hold", {13'd0, z0, o0, c0, s0}, {13'd0, q0[0]});
            end
            @(posedge clk); #1 or0 = 1'b1;
            @(negedge clk);
            chk("release in_ready", {31'd0, ir0}, 32'd1);
         end
      join
      w = 0;
      while (q0.size() != 0 && w < 40) begin
         @(posedge clk); #1;
         w++;
      end
      chk("stream drained", q0.size(), 32'd0);
      chk("stream outputs", n_out0 - base, 32'd10);

      @(posedge clk); #1;
      base = n_out0;
      for (int i = 0; i < 3; i++) begin
         a0 = 16'(16'h0100 + i); b0 = 16'h0011; m0 = i[0]; iv0 = 1'b1;
         @(posedge clk); #1;
      end
      iv0 = 1'b0;
      rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      chk("post-reset out_valid", {31'd0, ov0}, 32'd0);
      chk("post-reset in_ready", {31'd0, ir0}, 32'd1);
      repeat (10) @(posedge clk);
      #1;
      chk("no stale results", n_out0 - base, 32'd0);
      single(16'h1234, 16'h1234, 1'b1, {1'b1, 1'b0, 1'b1, 16'h0000});

      fork
         begin
            int cyc;
            cyc = 0;
            while (acc1 < 1000 && cyc < 10000) begin
               iv1 = ($urandom_range(0, 3) != 0);
               a1 = 8'($urandom); b1 = 8'($urandom); m1 = 1'($urandom);
               or1 = ($urandom_range(0, 4) != 0);
               @(posedge clk); #1;
               cyc++;
            end
            iv1 = 1'b0; or1 = 1'b1;
            cyc = 0;
            while (q1.size() != 0 && cyc < 50) begin
               @(posedge clk); #1;
               cyc++;
            end
            chk("w8s1 accepted", acc1, 32'd1000);
            chk("w8s1 drained", q1.size(), 32'd0);
         end
         begin
            int cyc;
            cyc = 0;
            while (acc2 < 1000 && cyc < 10000) begin
               iv2 = ($urandom_range(0, 3) != 0);
               a2 = 8'($urandom); b2 = 8'($urandom); m2 = 1'($urandom);
               or2 = ($urandom_range(0, 4) != 0);
               @(posedge clk); #1;
               cyc++;
            end
            iv2 = 1'b0; or2 = 1'b1;
            cyc = 0;
            while (q2.size() != 0 && cyc < 50) begin
               @(posedge clk); #1;
               cyc++;
            end
            chk("w8s8 accepted", acc2, 32'd1000);
            chk("w8s8 drained", q2.size(), 32'd0);
         end
      join

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
